// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that locks one byte-stream requester onto a shared UART transmitter for a whole packet.
// Optional idle-owner release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;

  logic            w_own_valid;
  logic            w_own_last;
  logic            w_xfer;
  logic [7:0]      w_own_data;
  logic            w_found;
  logic [PW-1:0]   w_win;
  int unsigned     w_idx;

  // The datapath is gated purely by r_grant, which is zero outside GRANT and clears asynchronously on reset.
  always_comb begin
    w_own_valid = |(req_valid & r_grant);
    w_own_last  = |(req_last & r_grant);
    w_own_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_own_data = w_own_data | req_data[8*i +: 8];
    end
  end

  assign w_xfer    = w_own_valid & tx_ready;
  assign tx_valid  = w_own_valid;
  assign tx_data   = w_own_valid ? w_own_data : '0;
  assign req_ready = r_grant & {NREQ{tx_ready}};
  assign grant     = r_grant;
  assign busy      = (r_state == GRANT);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_timeout_evt;
  assign timeout_evt = r_timeout_evt;
`else
  assign timeout_evt = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_ptr         <= PW'(NREQ - 1);
      r_owner       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_evt <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout_evt <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_grant <= NREQ'(1) << w_win;
            r_owner <= w_win;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        GRANT: begin
          if (w_xfer && w_own_last) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= r_owner;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (!w_own_valid) begin
            if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              r_state       <= IDLE;
              r_grant       <= '0;
              r_ptr         <= r_owner;
              r_cnt         <= '0;
              r_timeout_evt <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_cnt <= '0;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a packet-level owner/pointer model.
// Honours UART_ARB_TIMEOUT_EN with a 16-cycle idle threshold.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int W  = 2*N + 11;

  logic           clock;
  logic           resetb;
  logic [N-1:0]   r_valid;
  logic [8*N-1:0] r_data;
  logic [N-1:0]   r_last;
  logic           r_tx_ready;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_evt;
  logic [W-1:0]   w_obs;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index (-1 when nobody owns the transmitter), last owner pointer, idle count.
  int m_owner;
  int m_ptr;
  int m_idle;
  bit m_evt;

  uart_tx_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetb(resetb),
    .req_valid(r_valid), .req_data(r_data), .req_last(r_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(r_tx_ready),
    .grant(grant), .busy(busy), .timeout_evt(timeout_evt)
  );

  assign w_obs = {grant, busy, tx_valid, tx_data, req_ready, timeout_evt};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] exp_vec();
    logic [N-1:0] g, rdy;
    logic v;
    logic [7:0] d;
    g = '0; rdy = '0; v = 1'b0; d = '0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      v = r_valid[m_owner];
      if (v) d = r_data[8*m_owner +: 8];
      if (r_tx_ready) rdy[m_owner] = 1'b1;
    end
    return {g, (m_owner >= 0), v, d, rdy, m_evt};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_idle = 0; m_evt = 1'b0;
  endtask

  task automatic model_adv();
    m_evt = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (r_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_idle  = 0;
          break;
        end
      end
    end else begin
      if (r_valid[m_owner] && r_tx_ready && r_last[m_owner]) begin
        m_ptr = m_owner; m_owner = -1;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (!r_valid[m_owner]) begin
        m_idle++;
        if (m_idle == TO) begin
          m_ptr = m_owner; m_owner = -1; m_evt = 1'b1;
        end
      end else m_idle = 0;
`endif
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_adv();
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    r_valid = '0; r_data = '0; r_last = '0; r_tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    r_valid = '1; r_data = '1; r_last = '1; r_tx_ready = 1'b1;
    #3;
    n_checks++;
    if (w_obs !== '0) begin
      n_errors++; $display("FAIL reset_outputs got %h want 0", w_obs);
    end
    do_reset();
    #1;
    n_checks++;
    if (w_obs !== exp_vec()) begin
      n_errors++; $display("FAIL reset_release got %h want %h", w_obs, exp_vec());
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] b;
    do_reset();
    r_valid = 4'b0001; r_data[7:0] = 8'h41; r_tx_ready = 1'b1;
    #1;
    n_checks++;
    if (w_obs !== exp_vec() || tx_valid !== 1'b0 || grant !== 4'b0000) begin
      n_errors++; $display("FAIL pkt_idle got %h want %h", w_obs, exp_vec());
    end
    cyc();
    for (int i = 0; i < 3; i++) begin
      b = 8'h41 + 8'(i);
      r_data[7:0] = b; r_last[0] = (i == 2);
      #1;
      n_checks++;
      if (w_obs !== exp_vec() || grant !== 4'b0001 || tx_data !== b || req_ready !== 4'b0001) begin
        n_errors++; $display("FAIL pkt_byte%0d got grant=%b data=%h want grant=0001 data=%h", i, grant, tx_data, b);
      end
      cyc();
    end
    r_valid = '0; r_last = '0;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_errors++; $display("FAIL pkt_release got grant=%b busy=%b want 0000/0", grant, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    do_reset();
    r_valid = '1; r_last = '1; r_tx_ready = 1'b1; r_data = 32'h44332211;
    for (int c = 0; c < 10; c++) begin
      #1;
      want = (c % 2 == 0) ? 4'b0000 : 4'(1 << ((c / 2) % N));
      n_checks++;
      if (w_obs !== exp_vec() || grant !== want) begin
        n_errors++; $display("FAIL rr_cycle%0d got grant=%b want %b", c, grant, want);
      end
      cyc();
    end
  endtask

  task automatic test_lock();
    bit v3;
    logic [N-1:0] want;
    do_reset();
    // Walk the pointer to 1 so that requester 2 wins the next grant.
    r_valid = 4'b0010; r_last = 4'b0010; r_tx_ready = 1'b1;
    cyc(); cyc();
    r_valid = 4'b0100; r_last = '0; r_data = 32'hA0B0C0D0;
    cyc();
    r_valid = 4'b0101;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++;
      if (w_obs !== exp_vec() || grant !== 4'b0100 || req_ready[0] !== 1'b0) begin
        n_errors++; $display("FAIL lock_cycle%0d got grant=%b rdy=%b want 0100/0", c, grant, req_ready);
      end
      cyc();
    end
    v3 = 1'($urandom_range(0, 1));
    r_valid[3] = v3; r_last[2] = 1'b1;
    cyc();
    r_last = '0;
    cyc();
    #1;
    want = v3 ? 4'b1000 : 4'b0001;
    n_checks++;
    if (w_obs !== exp_vec() || grant !== want) begin
      n_errors++; $display("FAIL lock_next got grant=%b want %b", grant, want);
    end
  endtask

  task automatic test_stall();
    do_reset();
    r_valid = 4'b0010; r_data = 32'h0000_5A00; r_tx_ready = 1'b1;
    cyc();
    r_tx_ready = 1'b0;
    r_last = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      #1;
      n_checks++;
      if (w_obs !== exp_vec() || tx_valid !== 1'b1 || tx_data !== 8'h5A || req_ready !== '0 || grant !== 4'b0010) begin
        n_errors++; $display("FAIL stall_cycle%0d got v=%b d=%h rdy=%b g=%b want 1/5a/0000/0010", c, tx_valid, tx_data, req_ready, grant);
      end
      cyc();
    end
  endtask

  task automatic test_idle_owner();
    int pulses;
    pulses = 0;
    do_reset();
    r_valid = 4'b0001; r_tx_ready = 1'b1;
    cyc();
    r_valid = '0;
    for (int c = 0; c < 1000; c++) begin
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_errors++; $display("FAIL idle_owner_cycle%0d got %h want %h", c, w_obs, exp_vec());
      end
      if (timeout_evt === 1'b1) pulses++;
`ifndef UART_ARB_TIMEOUT_EN
      n_checks++;
      if (grant !== 4'b0001 || timeout_evt !== 1'b0) begin
        n_errors++; $display("FAIL hold_cycle%0d got grant=%b evt=%b want 0001/0", c, grant, timeout_evt);
      end
`else
      n_checks++;
      if ((c == TO && (timeout_evt !== 1'b1 || grant !== 4'b0000)) || (c < TO && grant !== 4'b0001)) begin
        n_errors++; $display("FAIL timeout_cycle%0d got grant=%b evt=%b", c, grant, timeout_evt);
      end
`endif
      cyc();
    end
`ifdef UART_ARB_TIMEOUT_EN
    n_checks++;
    if (pulses != 1) begin
      n_errors++; $display("FAIL timeout_pulses got %0d want 1", pulses);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    r_valid = 4'b0100; r_data = 32'h0077_0000; r_tx_ready = 1'b1;
    cyc(); cyc();
    r_data = 32'h0088_0000;
    #1;
    n_checks++;
    if (w_obs !== exp_vec() || tx_data !== 8'h88) begin
      n_errors++; $display("FAIL arst_byte2 got %h want 88", tx_data);
    end
    resetb = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== '0) begin
      n_errors++; $display("FAIL arst_outputs got %h want 0", w_obs);
    end
    model_reset();
    @(posedge clock);
    #1;
    resetb = 1'b1;
    r_valid = '1;
    cyc();
    #1;
    n_checks++;
    if (w_obs !== exp_vec() || grant !== 4'b0001) begin
      n_errors++; $display("FAIL arst_first_winner got grant=%b want 0001", grant);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r_valid    = N'($urandom) | N'($urandom);
      r_data     = 32'($urandom);
      r_last     = N'($urandom) & N'($urandom);
      r_tx_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (w_obs !== exp_vec()) begin
        n_errors++; $display("FAIL random_cycle%0d got %h want %h", c, w_obs, exp_vec());
      end
      cyc();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_lock();
    test_stall();
    test_idle_owner();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
